// File: rtl/wide_alu_axil_if.sv
// AXI4-Lite bus bundle for the wide-ALU register slave.
// The slave modport is the peripheral side, master is the interconnect side.
interface wide_alu_axil_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid,
    input  bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid,
    output arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid,
    output bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid,
    input  arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/wide_alu_axil.sv
// AXI4-Lite wide-operand ALU: A/B/R word banks, CTRL/STATUS,
// word-serial ADD/SUB/AND/XOR with carry chained across cycles.
module wide_alu_axil #(
  parameter int ADDR_WIDTH = 32,
  parameter int OP_WIDTH   = 256
) (
  input  logic            clk_i,
  input  logic            rst_i,
  wide_alu_axil_if.slave  s,
  output logic            busy_o,
  output logic            irq_o
);
  localparam int NW = OP_WIDTH / 32;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam int DW = (ADDR_WIDTH < 10) ? ADDR_WIDTH : 10;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [31:0]   a_q [NW];
  logic [31:0]   a_d [NW];
  logic [31:0]   b_q [NW];
  logic [31:0]   b_d [NW];
  logic [31:0]   r_q [NW];
  logic [31:0]   r_d [NW];
  logic [1:0]    op_q, op_d;
  logic          irq_en_q, irq_en_d;
  logic          done_q, done_d;
  logic          cout_q, cout_d;
  logic          c_q, c_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          rvalid_q, rvalid_d;
  logic [1:0]    rresp_q, rresp_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          irq_q, irq_d;

  logic [9:0]  aw_off, ar_off;
  logic [5:0]  aw_wi, ar_wi;
  logic        aw_hs, ar_hs, busy;
  logic        wr_err, start, clr_done;
  logic [31:0] a_cur, b_cur, res;
  logic [32:0] sum;

  function automatic logic [31:0] merge(
    input logic [31:0] o,
    input logic [31:0] d,
    input logic [3:0]  st
  );
    merge = o;
    for (int k = 0; k < 4; k++)
      if (st[k]) merge[8*k +: 8] = d[8*k +: 8];
  endfunction

  assign aw_off = 10'(s.awaddr[DW-1:0]);
  assign ar_off = 10'(s.araddr[DW-1:0]);
  assign aw_wi  = aw_off[7:2];
  assign ar_wi  = ar_off[7:2];
  assign busy   = (state_q == RUN);

  // Both channels are combinationally ready so a handshake costs one cycle.
  assign aw_hs     = s.awvalid & s.wvalid & ~bvalid_q & ~rst_i;
  assign s.awready = aw_hs;
  assign s.wready  = aw_hs;
  assign s.arready = ~rvalid_q & ~rst_i;
  assign ar_hs     = s.arvalid & s.arready;

  assign s.bvalid = bvalid_q;
  assign s.bresp  = bresp_q;
  assign s.rvalid = rvalid_q;
  assign s.rresp  = rresp_q;
  assign s.rdata  = rdata_q;
  assign busy_o   = busy;
  assign irq_o    = irq_q;

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    irq_en_d = irq_en_q;
    wr_err   = 1'b0;
    start    = 1'b0;
    clr_done = 1'b0;
    if (aw_hs) begin
      unique case (aw_off[9:8])
        2'd0: begin
          wr_err = 1'b1;
          for (int i = 0; i < NW; i++)
            if (aw_wi == 6'(i) && !busy) begin
              a_d[i] = merge(a_q[i], s.wdata, s.wstrb);
              wr_err = 1'b0;
            end
        end
        2'd1: begin
          wr_err = 1'b1;
          for (int i = 0; i < NW; i++)
            if (aw_wi == 6'(i) && !busy) begin
              b_d[i] = merge(b_q[i], s.wdata, s.wstrb);
              wr_err = 1'b0;
            end
        end
        2'd2: wr_err = 1'b1;
        default: begin
          if (aw_off[7:0] == 8'h00) begin
            if (busy) begin
              wr_err = 1'b1;
            end else begin
              if (s.wstrb[0]) begin
                op_d     = s.wdata[1:0];
                irq_en_d = s.wdata[4];
              end
              start = s.wstrb[1] & s.wdata[8];
            end
          end else if (aw_off[7:0] == 8'h04) begin
            clr_done = s.wstrb[0] & s.wdata[1];
          end else begin
            wr_err = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (bvalid_q && s.bready) bvalid_d = 1'b0;
    if (aw_hs) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_err ? SLVERR : OKAY;
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && s.rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = SLVERR;
      for (int i = 0; i < NW; i++)
        if (ar_wi == 6'(i) && ar_off[9:8] != 2'd3) begin
          rresp_d = OKAY;
          unique case (ar_off[9:8])
            2'd0:    rdata_d = a_q[i];
            2'd1:    rdata_d = b_q[i];
            default: rdata_d = r_q[i];
          endcase
        end
      if (ar_off == 10'h300) begin
        rresp_d = OKAY;
        rdata_d = {27'd0, irq_en_q, 2'b00, op_q};
      end else if (ar_off == 10'h304) begin
        rresp_d = OKAY;
        rdata_d = {29'd0, cout_q, done_q, busy};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    c_d     = c_q;
    r_d     = r_q;
    done_d  = done_q;
    cout_d  = cout_q;
    a_cur   = '0;
    b_cur   = '0;
    res     = '0;
    sum     = '0;
    if (clr_done) done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          c_d     = (op_d == 2'd1);
          done_d  = 1'b0;
        end
      end
      default: begin
        for (int i = 0; i < NW; i++)
          if (idx_q == IW'(i)) begin
            a_cur = a_q[i];
            b_cur = b_q[i];
          end
        // SUB is A + ~B + 1, the +1 entering as the initial carry.
        sum = {1'b0, a_cur}
            + {1'b0, (op_q == 2'd1) ? ~b_cur : b_cur}
            + 33'(c_q);
        unique case (op_q)
          2'd2:    res = a_cur & b_cur;
          2'd3:    res = a_cur ^ b_cur;
          default: begin
            res = sum[31:0];
            c_d = sum[32];
          end
        endcase
        for (int i = 0; i < NW; i++)
          if (idx_q == IW'(i)) r_d[i] = res;
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(NW - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cout_d  = op_q[1] ? 1'b0 : sum[32];
        end
      end
    endcase
    irq_d = done_d & irq_en_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      a_q      <= '{default: '0};
      b_q      <= '{default: '0};
      r_q      <= '{default: '0};
      op_q     <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      c_q      <= 1'b0;
      idx_q    <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= '0;
      rvalid_q <= 1'b0;
      rresp_q  <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      op_q     <= op_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      cout_q   <= cout_d;
      c_q      <= c_d;
      idx_q    <= idx_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end
endmodule

// File: tb/tb_wide_alu_axil.sv
// Bench for wide_alu_axil: directed corner cases plus random
// operand/op runs checked against a whole-vector arithmetic model.
module tb_wide_alu_axil;
  localparam int OPW = 256;
  localparam int NW  = OPW / 32;

  logic clk = 1'b0;
  logic rst;
  logic busy, irq;
  int   total = 0;
  int   bad   = 0;
  int   busy_total = 0;

  always #5 clk = ~clk;

  wide_alu_axil_if #(.ADDR_WIDTH(32)) bus();

  wide_alu_axil #(.ADDR_WIDTH(32), .OP_WIDTH(OPW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .s     (bus),
    .busy_o(busy),
    .irq_o (irq)
  );

  always @(negedge clk) if (busy) busy_total++;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [31:0] ma [NW];
  logic [31:0] mb [NW];
  logic [31:0] mr [NW];
  logic [1:0]  mop;
  logic        mien, mdone, mcarry;

  function automatic void m_reset();
    for (int i = 0; i < NW; i++) begin
      ma[i] = '0; mb[i] = '0; mr[i] = '0;
    end
    mop = '0; mien = 0; mdone = 0; mcarry = 0;
  endfunction

  function automatic logic [31:0] mrg(input logic [31:0] o,
      input logic [31:0] d, input logic [3:0] st);
    logic [31:0] v = o;
    for (int k = 0; k < 4; k++)
      if (st[k]) v[8*k +: 8] = d[8*k +: 8];
    return v;
  endfunction

  function automatic void m_run();
    logic [OPW-1:0] va, vb, vr;
    logic [OPW:0]   w;
    for (int i = 0; i < NW; i++) begin
      va[32*i +: 32] = ma[i];
      vb[32*i +: 32] = mb[i];
    end
    case (mop)
      2'd0: begin
        w = {1'b0, va} + {1'b0, vb};
        vr = w[OPW-1:0]; mcarry = w[OPW];
      end
      2'd1: begin
        vr = va - vb; mcarry = (va >= vb);
      end
      2'd2: begin vr = va & vb; mcarry = 0; end
      default: begin vr = va ^ vb; mcarry = 0; end
    endcase
    for (int i = 0; i < NW; i++) mr[i] = vr[32*i +: 32];
    mdone = 1;
  endfunction

  function automatic logic [1:0] m_wr(input logic [31:0] ad,
      input logic [31:0] d, input logic [3:0] st, input bit bsy);
    int off = int'(ad[9:0]);
    int wi  = (off >> 2) & 63;
    if (off < 'h100) begin
      if (wi >= NW || bsy) return 2'b10;
      ma[wi] = mrg(ma[wi], d, st); return 2'b00;
    end
    if (off < 'h200) begin
      if (wi >= NW || bsy) return 2'b10;
      mb[wi] = mrg(mb[wi], d, st); return 2'b00;
    end
    if (off < 'h300) return 2'b10;
    if (off == 'h300) begin
      if (bsy) return 2'b10;
      if (st[0]) begin mop = d[1:0]; mien = d[4]; end
      if (st[1] && d[8]) m_run();
      return 2'b00;
    end
    if (off == 'h304) begin
      if (st[0] && d[1]) mdone = 0;
      return 2'b00;
    end
    return 2'b10;
  endfunction

  function automatic logic [1:0] m_rd(input logic [31:0] ad,
      input bit bsy, output logic [31:0] d);
    int off = int'(ad[9:0]);
    int wi  = (off >> 2) & 63;
    d = '0;
    if (off < 'h300) begin
      if (wi >= NW) return 2'b10;
      if (off < 'h100) d = ma[wi];
      else if (off < 'h200) d = mb[wi];
      else d = mr[wi];
      return 2'b00;
    end
    if (off == 'h300) begin
      d = {27'd0, mien, 2'b00, mop}; return 2'b00;
    end
    if (off == 'h304) begin
      d = {29'd0, mcarry, mdone, bsy}; return 2'b00;
    end
    return 2'b10;
  endfunction

  task automatic axw(input logic [31:0] ad, input logic [31:0] d,
      input logic [3:0] st, output logic [1:0] resp);
    int n = 0;
    bus.awaddr = ad; bus.wdata = d; bus.wstrb = st;
    bus.awvalid = 1; bus.wvalid = 1; bus.bready = 1;
    @(negedge clk);
    while (!(bus.awready && bus.wready) && n < 50) begin
      @(negedge clk); n++;
    end
    if (n >= 50) chk("aw_timeout", 1, 0);
    @(posedge clk); #1;
    bus.awvalid = 0; bus.wvalid = 0;
    n = 0;
    @(negedge clk);
    while (!bus.bvalid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("b_timeout", 1, 0);
    resp = bus.bresp;
    @(posedge clk); #1;
    bus.bready = 0;
  endtask

  task automatic axr(input logic [31:0] ad, output logic [31:0] d,
      output logic [1:0] resp);
    int n = 0;
    bus.araddr = ad; bus.arvalid = 1; bus.rready = 1;
    @(negedge clk);
    while (!bus.arready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("ar_timeout", 1, 0);
    @(posedge clk); #1;
    bus.arvalid = 0;
    n = 0;
    @(negedge clk);
    while (!bus.rvalid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("r_timeout", 1, 0);
    d = bus.rdata; resp = bus.rresp;
    @(posedge clk); #1;
    bus.rready = 0;
  endtask

  task automatic wr_chk(input string tag, input logic [31:0] ad,
      input logic [31:0] d, input logic [3:0] st, input bit bsy);
    logic [1:0] exp, got;
    exp = m_wr(ad, d, st, bsy);
    axw(ad, d, st, got);
    chk(tag, got, exp);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] ad,
      input bit bsy);
    logic [31:0] ed, gd;
    logic [1:0]  er, gr;
    er = m_rd(ad, bsy, ed);
    axr(ad, gd, gr);
    chk({tag, "_data"}, gd, ed);
    chk({tag, "_resp"}, gr, er);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) chk("idle_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic run_op(input string tag, input logic [31:0] ctrl,
      input logic [3:0] st);
    int b0 = busy_total;
    wr_chk({tag, "_start"}, 32'h300, ctrl, st, 0);
    wait_idle();
    chk({tag, "_busylen"}, 64'(busy_total - b0), NW);
    for (int i = 0; i < NW; i++)
      rd_chk($sformatf("%s_r%0d", tag, i), 32'h200 + 4 * i, 0);
    rd_chk({tag, "_status"}, 32'h304, 0);
    @(negedge clk);
    chk({tag, "_irq"}, irq, mdone & mien);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r, er;
    int n;
    bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0;
    bus.wstrb = '0; bus.wvalid = 0; bus.bready = 0;
    bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
    rst = 1;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {busy, irq, bus.awready, bus.wready, bus.arready,
        bus.bvalid, bus.rvalid, bus.bresp, bus.rresp, bus.rdata}, 0);
    @(posedge clk); #1;
    rst = 0;
    rd_chk("rst_status", 32'h304, 0);
    rd_chk("rst_r0", 32'h200, 0);

    // All-ones + 1 ripples a carry through every word.
    for (int i = 0; i < NW; i++) begin
      wr_chk("add_a", 32'h000 + 4 * i, 32'hFFFF_FFFF, 4'hF, 0);
      wr_chk("add_b", 32'h100 + 4 * i, (i == 0) ? 1 : 0, 4'hF, 0);
    end
    run_op("add", 32'h100, 4'h3);
    rd_chk("add_st2", 32'h304, 0);

    for (int i = 0; i < NW; i++) begin
      wr_chk("sub_a", 32'h000 + 4 * i, (i == 0) ? 5 : 0, 4'hF, 0);
      wr_chk("sub_b", 32'h100 + 4 * i, (i == 0) ? 7 : 0, 4'hF, 0);
    end
    run_op("sub", 32'h101, 4'h3);
    axr(32'h200, d, r);
    chk("sub_r0_const", d, 32'hFFFF_FFFE);

    run_op("xor", 32'h113, 4'h3);
    chk("xor_irq_hi", irq, 1);
    wr_chk("w1c", 32'h304, 32'h2, 4'h1, 0);
    @(negedge clk);
    chk("w1c_irq_lo", irq, 0);
    @(posedge clk); #1;
    rd_chk("w1c_status", 32'h304, 0);
    rd_chk("ctrl_rd", 32'h300, 0);

    wr_chk("bz_start", 32'h300, 32'h100, 4'h3, 0);
    chk("bz_busy", busy, 1);
    wr_chk("bz_a0", 32'h000, 32'hDEAD_BEEF, 4'hF, 1);
    wr_chk("bz_restart", 32'h300, 32'h101, 4'h3, 1);
    rd_chk("bz_unmapped", 32'h3FC, 1);
    wait_idle();
    rd_chk("bz_a0_keep", 32'h000, 0);
    rd_chk("bz_r0", 32'h200, 0);
    rd_chk("bz_ctrl", 32'h300, 0);
    wr_chk("r_write", 32'h204, 32'h1, 4'hF, 0);
    wr_chk("b_oob", 32'h100 + 4 * NW, 32'h1, 4'hF, 0);

    // Hold the write response and check back-pressure on new writes.
    er = m_wr(32'h104, 32'h1234_5678, 4'hF, 0);
    bus.awaddr = 32'h104; bus.wdata = 32'h1234_5678; bus.wstrb = 4'hF;
    bus.awvalid = 1; bus.wvalid = 1; bus.bready = 0;
    n = 0;
    @(negedge clk);
    while (!bus.awready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("hold_aw_timeout", 1, 0);
    @(posedge clk); #1;
    bus.awaddr = 32'h008; bus.wdata = 32'h5555_5555;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_bvalid", bus.bvalid, 1);
      chk("hold_awready", bus.awready, 0);
    end
    @(posedge clk); #1;
    rd_chk("hold_rd_b1", 32'h104, 0);
    chk("hold_bvalid2", bus.bvalid, 1);
    bus.awvalid = 0; bus.wvalid = 0; bus.bready = 1;
    @(negedge clk);
    chk("hold_bresp", bus.bresp, er);
    @(posedge clk); #1;
    bus.bready = 0;
    @(negedge clk);
    chk("hold_bdrop", bus.bvalid, 0);
    @(posedge clk); #1;
    rd_chk("hold_a2", 32'h008, 0);

    for (int t = 0; t < 8; t++) begin
      logic [3:0]  st;
      logic [31:0] ctrl;
      for (int i = 0; i < NW; i++) begin
        st = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        wr_chk("rnd_a", 32'h000 + 4 * i, $urandom, st, 0);
        wr_chk("rnd_b", 32'h100 + 4 * i, $urandom, 4'hF, 0);
      end
      wr_chk("rnd_oob", 32'h000 + 4 * $urandom_range(NW, 63),
             $urandom, 4'hF, 0);
      ctrl = 32'h100 | 32'($urandom_range(0, 3))
           | (32'($urandom_range(0, 1)) << 4);
      st = ($urandom_range(0, 3) == 0) ? 4'h2 : 4'h3;
      run_op($sformatf("rnd%0d", t), ctrl, st);
      rd_chk("rnd_ctrl", 32'h300, 0);
      if ($urandom_range(0, 1) == 1)
        wr_chk("rnd_w1c", 32'h304, 32'h2, 4'h1, 0);
    end

    // Reset while running with a write response still pending.
    wr_chk("rs_start", 32'h300, 32'h110, 4'h3, 0);
    bus.awaddr = 32'h000; bus.wdata = 32'h1; bus.wstrb = 4'hF;
    bus.awvalid = 1; bus.wvalid = 1; bus.bready = 0;
    @(posedge clk); #1;
    bus.awvalid = 0; bus.wvalid = 0;
    @(negedge clk);
    chk("rs_pending", {busy, bus.bvalid}, 2'b11);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rs_outs", {busy, irq, bus.awready, bus.wready, bus.arready,
        bus.bvalid, bus.rvalid, bus.bresp, bus.rresp, bus.rdata}, 0);
    @(posedge clk); #1;
    rst = 0;
    m_reset();
    rd_chk("rs_status", 32'h304, 0);
    rd_chk("rs_a0", 32'h000, 0);
    rd_chk("rs_r3", 32'h20C, 0);
    rd_chk("rs_ctrl", 32'h300, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
